ysyx_23060201_load_unit: RTL and testbench
==========================================

Name: ysyx_23060201_load_unit

Overview:
Read-side counterpart to the core's data-memory write path. Accepts one load request at a time from the EXU and issues a word-aligned read to data memory over a valid/ready address/data channel pair. It then extracts and sign/zero-extends the addressed byte, halfword or word, and returns the result with its destination register for GPR write-back. The core stalls on req_ready/resp_valid. The block detects misalignment, illegal width, memory error responses and response timeout.

Parameters:
ADDR_WIDTH, 32, width of load byte address
DATA_WIDTH, 32, memory data width (fixed 32; other values unsupported)
TIMEOUT, 255, max cycles waiting in R_WAIT for mem_rvalid before error

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  load request valid
req_ready  out  1  unit can accept request (high only in IDLE)
req_addr  in  ADDR_WIDTH  byte address
req_func3  in  3  RV32I load funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101)
req_rd  in  5  destination register
resp_valid  out  1  result valid
resp_ready  in  1  consumer accepts result
resp_data  out  32  extended load data (0 on error)
resp_rd  out  5  destination register echoed
resp_err  out  1  1 = misaligned / illegal func3 / bus error / timeout
mem_arvalid  out  1  read address valid
mem_arready  in  1  memory accepts address
mem_araddr  out  ADDR_WIDTH  {req_addr[ADDR_WIDTH-1:2],2'b00}
mem_rvalid  in  1  read data valid
mem_rready  out  1  unit accepts read data
mem_rdata  in  32  little-endian word
mem_rresp  in  2  00 OK, nonzero = error

Behaviour:
- Reset (rst=1 at an edge): state IDLE; req_ready=1, resp_valid=0, resp_err=0, resp_data=0, resp_rd=0, mem_arvalid=0, mem_rready=0, timeout counter=0. Reset mid-transaction abandons it; the memory side is reset by the same rst.
- States: IDLE, AR, R_WAIT, RESP, DRAIN.
- IDLE: req_ready=1. On req_valid, latch addr[1:0], func3, rd and word address.
  - If func3 ∈ {011,110,111}, LH/LHU with addr[0]=1, or LW with addr[1:0]≠0: go to RESP with err=1, data=0. No memory access.
  - Otherwise go to AR.
- AR: mem_arvalid=1; mem_araddr stable until handshake. On mem_arready, go to R_WAIT and clear the counter. arvalid never drops without a handshake.
- R_WAIT: mem_rready=1; the counter increments each cycle without rvalid.
  - On mem_rvalid with rresp≠00: RESP, err=1, data=0.
  - On mem_rvalid with rresp=00: RESP, err=0, data=extract(mem_rdata).
  - rvalid in the same cycle the counter hits TIMEOUT: data wins.
  - Counter==TIMEOUT without rvalid: RESP with err=1, data=0, and set a pending-drain flag.
- Extraction uses the byte at lane addr[1:0] (bits 8*k+7:8*k) and the halfword at lane addr[1] (bits 16*h+15:16*h):
  - LB: sign-extend bit 7 of the byte.
  - LBU: zero-extend the byte.
  - LH: sign-extend bit 15 of the halfword.
  - LHU: zero-extend the halfword.
  - LW: full word.
- RESP: resp_valid=1; resp_data/rd/err held stable until resp_ready. On resp_ready, go to DRAIN if drain is pending, else IDLE. Throughput is one load per four cycles minimum; with zero-wait memory and resp_ready high, the sequence is IDLE→AR→R_WAIT→RESP→IDLE.
- DRAIN: mem_rready=1, req_ready=0. The late mem_rvalid beat is discarded, then go to IDLE. If no beat arrives, DRAIN persists until reset.
- Outputs are registered; no combinational path from mem_* to resp_*. req_ready depends only on state.
- resp_valid never asserts without a prior accepted req. Exactly one resp per accepted req.

Test Plan:
- LW at 0x80000004, mem returns 0xDEADBEEF after 0 wait, resp_ready=1 → ar handshake with araddr 0x80000004; resp_valid 3 cycles after req accept; data 0xDEADBEEF, err=0, rd echoed.
- LB/LBU at 0x80000003, rdata 0x80FF7F01 → LB gives 0xFFFFFF80, LBU gives 0x00000080; LH at 0x80000002 gives 0xFFFF80FF, LHU gives 0x000080FF.
- LW at 0x80000002, then func3=011 → resp err=1, data=0, mem_arvalid never asserts.
- mem_arready held low 5 cycles, then rvalid after 3 cycles with rresp=10 → arvalid/araddr stable for 5 cycles; resp err=1, data=0.
- TIMEOUT=4, rvalid withheld → err resp after 4 R_WAIT cycles; req_ready stays 0 until the late rvalid beat is drained; the next LW completes normally. Separately, resp_ready low 3 cycles → resp fields stable.
- rst asserted in R_WAIT and in RESP → next cycle req_ready=1, resp_valid=0, mem_arvalid=0, mem_rready=0; the following load is correct.

Source files
------------

// File: rtl/ysyx_23060201_load_unit.sv
// ============================================================================
// Module  : ysyx_23060201_load_unit
// Brief   : RV32I load unit - word read over valid/ready AR/R channels, then
//           byte/halfword/word extraction with error and timeout reporting.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060201_load_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [2:0]            req_func3,
    input  logic [4:0]            req_rd,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_data,
    output logic [4:0]            resp_rd,
    output logic                  resp_err,
    output logic                  mem_arvalid,
    input  logic                  mem_arready,
    output logic [ADDR_WIDTH-1:0] mem_araddr,
    input  logic                  mem_rvalid,
    output logic                  mem_rready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic [1:0]            mem_rresp
);

    localparam int            CW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_AR    = 3'd1,
        S_RWAIT = 3'd2,
        S_RESP  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    r_lane;
    logic [2:0]    r_func3;
    logic          r_drain;
    logic [CW-1:0] r_cnt;
    logic          w_bad_req;
    logic          w_timeout;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_ext;

    // Handshake outputs are pure state decodes, so none of them sees mem_* combinationally.
    assign req_ready   = (r_state == S_IDLE);
    assign mem_arvalid = (r_state == S_AR);
    assign mem_rready  = (r_state == S_RWAIT) || (r_state == S_DRAIN);
    assign resp_valid  = (r_state == S_RESP);

    always_comb begin
        w_bad_req = 1'b0;
        case (req_func3)
            3'b000, 3'b100: w_bad_req = 1'b0;
            3'b001, 3'b101: w_bad_req = req_addr[0];
            3'b010:         w_bad_req = (req_addr[1:0] != 2'b00);
            default:        w_bad_req = 1'b1;
        endcase
    end

    // Timeout only fires when no beat arrives in the last allowed cycle.
    assign w_timeout = (r_state == S_RWAIT) && !mem_rvalid && (r_cnt == TO_LAST);

    always_comb begin
        w_byte = mem_rdata[{r_lane, 3'b000} +: 8];
        w_half = mem_rdata[{r_lane[1], 4'b0000} +: 16];
        w_ext  = 32'd0;
        case (r_func3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b010:  w_ext = mem_rdata[31:0];
            3'b100:  w_ext = {24'd0, w_byte};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = 32'd0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_next = w_bad_req ? S_RESP : S_AR;
            S_AR:    if (mem_arready) w_next = S_RWAIT;
            S_RWAIT: if (mem_rvalid || w_timeout) w_next = S_RESP;
            S_RESP:  if (resp_ready) w_next = r_drain ? S_DRAIN : S_IDLE;
            S_DRAIN: if (mem_rvalid) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane     <= 2'd0;
            r_func3    <= 3'd0;
            r_drain    <= 1'b0;
            r_cnt      <= '0;
            resp_data  <= 32'd0;
            resp_rd    <= 5'd0;
            resp_err   <= 1'b0;
            mem_araddr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_lane     <= req_addr[1:0];
                        r_func3    <= req_func3;
                        resp_rd    <= req_rd;
                        mem_araddr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        if (w_bad_req) begin
                            resp_err  <= 1'b1;
                            resp_data <= 32'd0;
                        end
                    end
                end
                S_AR: begin
                    if (mem_arready) r_cnt <= '0;
                end
                S_RWAIT: begin
                    if (mem_rvalid) begin
                        resp_err  <= (mem_rresp != 2'b00);
                        resp_data <= (mem_rresp != 2'b00) ? 32'd0 : w_ext;
                    end else if (w_timeout) begin
                        resp_err  <= 1'b1;
                        resp_data <= 32'd0;
                        r_drain   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // The abandoned beat is swallowed here so it cannot answer a later request.
                    if (mem_rvalid) r_drain <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060201_load_unit.sv
// ============================================================================
// Module  : tb_ysyx_23060201_load_unit
// Brief   : Directed self-checking bench for the load unit (TIMEOUT=4).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_23060201_load_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_func3;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_err;
    logic        mem_arvalid;
    logic        mem_arready;
    logic [31:0] mem_araddr;
    logic        mem_rvalid;
    logic        mem_rready;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_rresp;

    int n_checks = 0;
    int n_err    = 0;

    // Results captured by serve()
    int          got_lat, got_ar_cyc, got_r_cyc;
    logic        got_done, got_ar_stable, got_stable, got_err;
    logic [31:0] got_data, got_ar_addr;
    logic [4:0]  got_rd;

    ysyx_23060201_load_unit #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_func3  (req_func3),
        .req_rd     (req_rd),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_rd    (resp_rd),
        .resp_err   (resp_err),
        .mem_arvalid(mem_arvalid),
        .mem_arready(mem_arready),
        .mem_araddr (mem_araddr),
        .mem_rvalid (mem_rvalid),
        .mem_rready (mem_rready),
        .mem_rdata  (mem_rdata),
        .mem_rresp  (mem_rresp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd);
        int w;
        w = 0;
        while (!req_ready && w < 50) begin
            tick();
            w++;
        end
        if (!req_ready) chk("req_ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_func3 = f3;
        req_rd    = rd;
        tick();
        req_valid = 1'b0;
    endtask

    // Acts as the memory: AR accepted after ar_wait stalled cycles, R beat after r_wait empty cycles.
    task automatic serve(input int ar_wait, input int r_wait, input logic [31:0] rdata,
                         input logic [1:0] rresp, input int hold);
        int k;
        k             = 1;
        got_done      = 1'b0;
        got_ar_cyc    = 0;
        got_r_cyc     = 0;
        got_ar_stable = 1'b1;
        got_stable    = 1'b1;
        got_ar_addr   = 32'hx;
        resp_ready    = (hold == 0);
        while (!got_done && k <= 64) begin
            mem_arready = 1'b0;
            mem_rvalid  = 1'b0;
            if (resp_valid) begin
                got_done = 1'b1;
                got_lat  = k;
                got_data = resp_data;
                got_err  = resp_err;
                got_rd   = resp_rd;
            end else begin
                if (mem_arvalid) begin
                    got_ar_cyc++;
                    if (got_ar_cyc == 1) got_ar_addr = mem_araddr;
                    else if (mem_araddr !== got_ar_addr) got_ar_stable = 1'b0;
                    mem_arready = (got_ar_cyc > ar_wait);
                end
                if (mem_rready) begin
                    got_r_cyc++;
                    if (got_r_cyc > r_wait) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = rdata;
                        mem_rresp  = rresp;
                    end
                end
                tick();
                k++;
            end
        end
        if (!got_done) chk("resp_wait_bound", 32'(got_done), 32'd1);
        for (int h = 0; h < hold; h++) begin
            tick();
            if (!(resp_valid && resp_data === got_data && resp_err === got_err && resp_rd === got_rd))
                got_stable = 1'b0;
        end
        resp_ready = 1'b1;
        tick();
    endtask

    initial begin
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_addr    = 32'd0;
        req_func3   = 3'd0;
        req_rd      = 5'd0;
        resp_ready  = 1'b1;
        mem_arready = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'd0;
        mem_rresp   = 2'b00;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_rd", 32'(resp_rd), 32'd0);
        chk("rst_arvalid", 32'(mem_arvalid), 32'd0);
        chk("rst_rready", 32'(mem_rready), 32'd0);

        // LW, zero-wait memory
        issue(32'h8000_0004, 3'b010, 5'd5);
        serve(0, 0, 32'hDEAD_BEEF, 2'b00, 0);
        chk("lw_araddr", got_ar_addr, 32'h8000_0004);
        chk("lw_latency", 32'(got_lat), 32'd3);
        chk("lw_data", got_data, 32'hDEAD_BEEF);
        chk("lw_err", 32'(got_err), 32'd0);
        chk("lw_rd", 32'(got_rd), 32'd5);

        // Sign/zero extension across lanes
        issue(32'h8000_0003, 3'b000, 5'd6);
        serve(0, 0, 32'h80FF_7F01, 2'b00, 0);
        chk("lb_lane3", got_data, 32'hFFFF_FF80);
        chk("lb_araddr", got_ar_addr, 32'h8000_0000);
        issue(32'h8000_0003, 3'b100, 5'd7);
        serve(0, 0, 32'h80FF_7F01, 2'b00, 0);
        chk("lbu_lane3", got_data, 32'h0000_0080);
        issue(32'h8000_0001, 3'b000, 5'd7);
        serve(0, 0, 32'h80FF_7F01, 2'b00, 0);
        chk("lb_lane1", got_data, 32'h0000_007F);
        issue(32'h8000_0002, 3'b001, 5'd8);
        serve(0, 0, 32'h80FF_7F01, 2'b00, 0);
        chk("lh_lane1", got_data, 32'hFFFF_80FF);
        issue(32'h8000_0002, 3'b101, 5'd9);
        serve(0, 0, 32'h80FF_7F01, 2'b00, 0);
        chk("lhu_lane1", got_data, 32'h0000_80FF);
        issue(32'h8000_0000, 3'b001, 5'd9);
        serve(0, 0, 32'h80FF_7F01, 2'b00, 0);
        chk("lh_lane0", got_data, 32'h0000_7F01);

        // Misaligned / illegal requests never touch memory
        issue(32'h8000_0002, 3'b010, 5'd10);
        serve(0, 0, 32'h1111_1111, 2'b00, 0);
        chk("lw_mis_err", 32'(got_err), 32'd1);
        chk("lw_mis_data", got_data, 32'd0);
        chk("lw_mis_noar", 32'(got_ar_cyc), 32'd0);
        chk("lw_mis_rd", 32'(got_rd), 32'd10);
        issue(32'h8000_0000, 3'b011, 5'd11);
        serve(0, 0, 32'h1111_1111, 2'b00, 0);
        chk("f3_011_err", 32'(got_err), 32'd1);
        chk("f3_011_noar", 32'(got_ar_cyc), 32'd0);
        issue(32'h8000_0001, 3'b101, 5'd11);
        serve(0, 0, 32'h1111_1111, 2'b00, 0);
        chk("lhu_mis_err", 32'(got_err), 32'd1);

        // Stalled AR channel, then bus error response
        issue(32'h8000_0010, 3'b010, 5'd12);
        serve(5, 3, 32'h2222_2222, 2'b10, 0);
        chk("arstall_cycles", 32'(got_ar_cyc), 32'd6);
        chk("arstall_stable", 32'(got_ar_stable), 32'd1);
        chk("arstall_addr", got_ar_addr, 32'h8000_0010);
        chk("buserr_err", 32'(got_err), 32'd1);
        chk("buserr_data", got_data, 32'd0);
        chk("buserr_no_drain", 32'(req_ready), 32'd1);

        // Beat in the final allowed R_WAIT cycle beats the timeout
        issue(32'h8000_0001, 3'b100, 5'd13);
        serve(0, 3, 32'h0000_AB00, 2'b00, 0);
        chk("edge_data", got_data, 32'h0000_00AB);
        chk("edge_err", 32'(got_err), 32'd0);
        chk("edge_no_drain", 32'(req_ready), 32'd1);

        // Timeout, then drain of the late beat
        issue(32'h8000_0008, 3'b010, 5'd14);
        serve(0, 1000, 32'h0, 2'b00, 0);
        chk("to_rwait_cycles", 32'(got_r_cyc), 32'd4);
        chk("to_latency", 32'(got_lat), 32'd6);
        chk("to_err", 32'(got_err), 32'd1);
        chk("to_data", got_data, 32'd0);
        chk("to_rd", 32'(got_rd), 32'd14);
        for (int i = 0; i < 3; i++) begin
            chk("drain_req_ready", 32'(req_ready), 32'd0);
            chk("drain_rready", 32'(mem_rready), 32'd1);
            tick();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        tick();
        mem_rvalid = 1'b0;
        chk("drain_done_ready", 32'(req_ready), 32'd1);
        issue(32'h8000_0008, 3'b010, 5'd15);
        serve(0, 0, 32'h1234_5678, 2'b00, 0);
        chk("post_drain_data", got_data, 32'h1234_5678);
        chk("post_drain_err", 32'(got_err), 32'd0);

        // Consumer back-pressure holds the response
        issue(32'h8000_0002, 3'b101, 5'd16);
        serve(0, 1, 32'hA5A5_1234, 2'b00, 3);
        chk("hold_stable", 32'(got_stable), 32'd1);
        chk("hold_data", got_data, 32'h0000_A5A5);
        chk("hold_rd", 32'(got_rd), 32'd16);

        // Reset while in R_WAIT
        issue(32'h8000_0020, 3'b010, 5'd17);
        for (int i = 0; i < 10 && !mem_rready; i++) begin
            mem_arready = mem_arvalid;
            tick();
        end
        mem_arready = 1'b0;
        chk("rwait_reached", 32'(mem_rready), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstw_req_ready", 32'(req_ready), 32'd1);
        chk("rstw_resp_valid", 32'(resp_valid), 32'd0);
        chk("rstw_arvalid", 32'(mem_arvalid), 32'd0);
        chk("rstw_rready", 32'(mem_rready), 32'd0);
        issue(32'h8000_0000, 3'b001, 5'd18);
        serve(0, 0, 32'h0000_8001, 2'b00, 0);
        chk("rstw_next_data", got_data, 32'hFFFF_8001);
        chk("rstw_next_rd", 32'(got_rd), 32'd18);

        // Reset while in RESP
        resp_ready = 1'b0;
        issue(32'h8000_0001, 3'b010, 5'd19);
        chk("resp_reached", 32'(resp_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        resp_ready = 1'b1;
        chk("rstr_req_ready", 32'(req_ready), 32'd1);
        chk("rstr_resp_valid", 32'(resp_valid), 32'd0);
        chk("rstr_resp_err", 32'(resp_err), 32'd0);
        chk("rstr_arvalid", 32'(mem_arvalid), 32'd0);
        chk("rstr_rready", 32'(mem_rready), 32'd0);
        issue(32'h8000_000C, 3'b010, 5'd20);
        serve(0, 2, 32'hCAFE_F00D, 2'b00, 0);
        chk("rstr_next_data", got_data, 32'hCAFE_F00D);
        chk("rstr_next_err", 32'(got_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
